pooling_stream_nxn: RTL and testbench

- Streaming successor to the flattened-array average pooling block.
- Accepts a raster-order pixel stream, CHANNELS pixels per beat, and pools each non-overlapping NxN window.
- Per-frame selectable mode: average or max.
- Emits pooled pixels in raster order with valid/ready backpressure; sits between the camera/preprocessing stream and the classifier input buffer.
- Replaces the full-frame combinational pooling array with an OUT_SIDE-deep accumulator line.

---
 rtl/pooling_pkg.sv | 12 +
 rtl/pool_combine.sv | 42 ++++
 rtl/pooling_stream_nxn.sv | 137 +++++++++++++
 tb/tb_pooling_stream_nxn.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pooling_pkg.sv
// Shared constants and helpers for the streaming NxN pooling block.
package pooling_pkg;

  localparam logic POOL_MODE_AVG = 1'b0;
  localparam logic POOL_MODE_MAX = 1'b1;

  // Width needed to hold N*N full-scale pixels without overflow.
  function automatic int acc_width(input int res, input int n);
    return res + 2 * $clog2(n);
  endfunction

endpackage

// File: rtl/pool_combine.sv
// Per-channel combine (add or unsigned max) and final average shift.
// POOL_ROUND_EN selects half-up rounding of the average instead of truncation.
module pool_combine
  import pooling_pkg::*;
#(
  parameter int RESOLUTION = 8,
  parameter int N          = 2,
  parameter int ACC_W      = acc_width(RESOLUTION, N)
)(
  input  logic [ACC_W-1:0]      i_acc,
  input  logic [RESOLUTION-1:0] i_pix,
  input  logic                  i_first,
  input  logic                  i_mode,
  output logic [ACC_W-1:0]      o_comb,
  output logic [RESOLUTION-1:0] o_result
);
  localparam int SH = 2 * $clog2(N);

  logic [ACC_W-1:0]      w_pix_ext;
  logic [RESOLUTION-1:0] w_avg;

  assign w_pix_ext = ACC_W'(i_pix);

  always_comb begin
    o_comb = i_acc + w_pix_ext;
    if (i_first)                       o_comb = w_pix_ext;
    else if (i_mode == POOL_MODE_MAX)  o_comb = (i_acc > w_pix_ext) ? i_acc : w_pix_ext;
  end

`ifdef POOL_ROUND_EN
  // One extra bit so the full-scale sum plus half cannot wrap.
  localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(1) << (SH - 1);
  logic [ACC_W:0] w_sum;
  assign w_sum = {1'b0, o_comb} + HALF;
  assign w_avg = RESOLUTION'(w_sum >> SH);
`else
  assign w_avg = RESOLUTION'(o_comb >> SH);
`endif

  assign o_result = (i_mode == POOL_MODE_MAX) ? RESOLUTION'(o_comb) : w_avg;

endmodule

// File: rtl/pooling_stream_nxn.sv
// Streaming NxN non-overlapping pooling (average or max) over a raster pixel stream.
// Optional POOL_ROUND_EN (in pool_combine) rounds the average half-up.
module pooling_stream_nxn
  import pooling_pkg::*;
#(
  parameter int RESOLUTION = 8,
  parameter int N          = 2,
  parameter int IN_SIDE    = 28,
  parameter int CHANNELS   = 1,
  parameter int OUT_SIDE   = IN_SIDE / N,
  parameter int ACC_W      = acc_width(RESOLUTION, N)
)(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           mode,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHANNELS*RESOLUTION-1:0] in_pixels,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS*RESOLUTION-1:0] out_pixels,
  output logic                           out_last,
  output logic                           frame_busy
);
  generate
    if (IN_SIDE % N != 0) begin : g_bad_side
      $error("IN_SIDE must be a multiple of N");
    end
    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
      $error("N must be a power of 2 and at least 2");
    end
    if (OUT_SIDE != IN_SIDE / N) begin : g_bad_out
      $error("OUT_SIDE is derived and must equal IN_SIDE/N");
    end
  endgenerate

  localparam int CW = $clog2(N);
  localparam int PW = (OUT_SIDE > 1) ? $clog2(OUT_SIDE) : 1;
  localparam logic [CW-1:0] CIP_LAST  = CW'(N - 1);
  localparam logic [PW-1:0] POOL_LAST = PW'(OUT_SIDE - 1);

  logic [CW-1:0] r_cip, r_srow;
  logic [PW-1:0] r_pcol, r_prow;
  logic          r_mode, r_out_valid, r_out_last, r_busy;
  logic [CHANNELS-1:0][RESOLUTION-1:0] r_out_pix;
  logic [CHANNELS-1:0][ACC_W-1:0]      r_acc [OUT_SIDE];

  logic w_in_xfer, w_out_xfer, w_start, w_first, w_done, w_last, w_mode, w_load;
  logic [CHANNELS-1:0][ACC_W-1:0]      w_acc_rd, w_comb;
  logic [CHANNELS-1:0][RESOLUTION-1:0] w_res;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;
  assign w_start    = (r_cip == '0) && (r_pcol == '0) && (r_srow == '0) && (r_prow == '0);
  assign w_first    = (r_srow == '0) && (r_cip == '0);
  assign w_done     = (r_srow == CIP_LAST) && (r_cip == CIP_LAST);
  assign w_last     = (r_prow == POOL_LAST) && (r_pcol == POOL_LAST);
  // The first beat of a frame already uses the incoming mode.
  assign w_mode     = w_start ? mode : r_mode;
  assign w_load     = w_in_xfer && w_done;
  assign w_acc_rd   = r_acc[r_pcol];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    pool_combine #(.RESOLUTION(RESOLUTION), .N(N), .ACC_W(ACC_W)) u_comb (
      .i_acc    (w_acc_rd[c]),
      .i_pix    (in_pixels[c*RESOLUTION +: RESOLUTION]),
      .i_first  (w_first),
      .i_mode   (w_mode),
      .o_comb   (w_comb[c]),
      .o_result (w_res[c])
    );
  end

  // Completed windows go straight to the output register, never back to the line.
  always_ff @(posedge clk) begin
    if (w_in_xfer && !w_done) r_acc[r_pcol] <= w_comb;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cip  <= '0;
      r_pcol <= '0;
      r_srow <= '0;
      r_prow <= '0;
    end else if (w_in_xfer) begin
      if (r_cip == CIP_LAST) begin
        r_cip <= '0;
        if (r_pcol == POOL_LAST) begin
          r_pcol <= '0;
          if (r_srow == CIP_LAST) begin
            r_srow <= '0;
            r_prow <= (r_prow == POOL_LAST) ? '0 : r_prow + 1'b1;
          end else begin
            r_srow <= r_srow + 1'b1;
          end
        end else begin
          r_pcol <= r_pcol + 1'b1;
        end
      end else begin
        r_cip <= r_cip + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_pix   <= '0;
      r_busy      <= 1'b0;
      r_mode      <= POOL_MODE_AVG;
    end else begin
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_pix   <= w_res;
        r_out_last  <= w_last;
      end else if (w_out_xfer) begin
        r_out_valid <= 1'b0;
        r_out_pix   <= '0;
        r_out_last  <= 1'b0;
      end
      if (w_out_xfer && r_out_last) r_busy <= 1'b0;
      // A new frame starting on the same edge keeps busy asserted.
      if (w_in_xfer && w_start) begin
        r_busy <= 1'b1;
        r_mode <= mode;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_pixels = r_out_pix;
  assign out_last   = r_out_last;
  assign frame_busy = r_busy;

endmodule

// File: tb/tb_pooling_stream_nxn.sv
// Scoreboard bench: dut_a (N=2, 4x4, 3 channels) and dut_b (N=4, 8x8, 1 channel).
module tb_pooling_stream_nxn;
`ifdef POOL_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        a_mode = 1'b0, a_vld = 1'b0, a_ordy = 1'b1;
  logic        a_rdy, a_ovld, a_olast, a_busy;
  logic [23:0] a_px = '0, a_opx;
  logic        b_mode = 1'b0, b_vld = 1'b0, b_ordy = 1'b1;
  logic        b_rdy, b_ovld, b_olast, b_busy;
  logic [7:0]  b_px = '0, b_opx;

  typedef struct packed { logic [23:0] px; logic last; } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int n_cmp = 0, n_bad = 0;

  pooling_stream_nxn #(.RESOLUTION(8), .N(2), .IN_SIDE(4), .CHANNELS(3)) dut_a (
    .clk(clk), .reset(rst_n), .mode(a_mode), .in_valid(a_vld), .in_ready(a_rdy),
    .in_pixels(a_px), .out_valid(a_ovld), .out_ready(a_ordy), .out_pixels(a_opx),
    .out_last(a_olast), .frame_busy(a_busy));

  pooling_stream_nxn #(.RESOLUTION(8), .N(4), .IN_SIDE(8), .CHANNELS(1)) dut_b (
    .clk(clk), .reset(rst_n), .mode(b_mode), .in_valid(b_vld), .in_ready(b_rdy),
    .in_pixels(b_px), .out_valid(b_ovld), .out_ready(b_ordy), .out_pixels(b_opx),
    .out_last(b_olast), .frame_busy(b_busy));

  function automatic logic [23:0] px3(input int c0, input int c1, input int c2);
    return {c2[7:0], c1[7:0], c0[7:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic push_a(input int c0, input int c1, input int c2, input logic last);
    exp_t e;
    e.px = px3(c0, c1, c2);
    e.last = last;
    qa.push_back(e);
  endtask

  // Inputs change #1 after posedge; ready is judged on the negedge before the transfer edge.
  task automatic beat_a(input logic [23:0] px);
    int t = 0;
    a_px = px; a_vld = 1'b1;
    @(negedge clk);
    while (!a_rdy && t < 50) begin @(negedge clk); t++; end
    if (!a_rdy) begin
      n_cmp++; n_bad++;
      $display("FAIL a_in_ready_timeout: got in_ready 0 expected 1 within 50 cycles");
    end else begin
      @(posedge clk); #1;
    end
    a_vld = 1'b0;
  endtask

  task automatic beat_b(input logic [7:0] px);
    int t = 0;
    b_px = px; b_vld = 1'b1;
    @(negedge clk);
    while (!b_rdy && t < 50) begin @(negedge clk); t++; end
    if (!b_rdy) begin
      n_cmp++; n_bad++;
      $display("FAIL b_in_ready_timeout: got in_ready 0 expected 1 within 50 cycles");
    end else begin
      @(posedge clk); #1;
    end
    b_vld = 1'b0;
  endtask

  task automatic drain_a();
    for (int t = 0; t < 40 && qa.size() != 0; t++) begin @(negedge clk); #1; end
    chk("a_drain_pending", qa.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic drain_b();
    for (int t = 0; t < 40 && qb.size() != 0; t++) begin @(negedge clk); #1; end
    chk("b_drain_pending", qb.size(), 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (a_ovld && a_ordy) begin
      n_cmp++;
      if (qa.size() == 0) begin
        n_bad++;
        $display("FAIL a_out_extra: got %h last %b expected no output", a_opx, a_olast);
      end else begin
        ea = qa.pop_front();
        if (a_opx !== ea.px || a_olast !== ea.last) begin
          n_bad++;
          $display("FAIL a_out: got %h last %b expected %h last %b", a_opx, a_olast, ea.px, ea.last);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_ovld && b_ordy) begin
      n_cmp++;
      if (qb.size() == 0) begin
        n_bad++;
        $display("FAIL b_out_extra: got %h last %b expected no output", b_opx, b_olast);
      end else begin
        eb = qb.pop_front();
        if (b_opx !== eb.px[7:0] || b_olast !== eb.last) begin
          n_bad++;
          $display("FAIL b_out: got %h last %b expected %h last %b", b_opx, b_olast, eb.px[7:0], eb.last);
        end
      end
    end
  end

  initial begin
    int av0[4], av1[4];
    int mx0[4] = '{5, 7, 13, 15};
    int mx1[4] = '{255, 253, 247, 245};
    int rpat[16] = '{1, 1, 1, 1, 1, 2, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0};
    int rexp[4];
    exp_t e;
    if (RND) begin
      av0 = '{3, 5, 11, 13};
      av1 = '{253, 251, 245, 243};
      rexp = '{1, 2, 0, 0};
    end else begin
      av0 = '{2, 4, 10, 12};
      av1 = '{252, 250, 244, 242};
      rexp = '{1, 1, 0, 0};
    end

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", a_ovld, 0);
    chk("rst_out_pixels", a_opx, 0);
    chk("rst_out_last", a_olast, 0);
    chk("rst_frame_busy", a_busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", a_rdy, 1);
    chk("rst_b_out_valid", b_ovld, 0);

    // Average frame, backpressure after first result, mode flipped mid-frame
    for (int k = 0; k < 4; k++) push_a(av0[k], av1[k], 7, k == 3);
    a_mode = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) a_ordy = 1'b0;
      if (i == 8) a_mode = 1'b1;
      beat_a(px3(i, 255 - i, 7));
      if (i == 0) chk("busy_after_first", a_busy, 1);
      if (i == 5) begin
        repeat (3) @(negedge clk);
        chk("hold_out_valid", a_ovld, 1);
        chk("hold_out_pixels", a_opx, px3(av0[0], av1[0], 7));
        chk("hold_out_last", a_olast, 0);
        chk("hold_in_ready", a_rdy, 0);
        @(posedge clk); #1;
        a_ordy = 1'b1;
      end
    end
    drain_a();
    chk("busy_end_f1", a_busy, 0);

    // Max frame (mode latched high), flip back low mid-frame
    for (int k = 0; k < 4; k++) push_a(mx0[k], mx1[k], 7, k == 3);
    for (int i = 0; i < 16; i++) begin
      if (i == 3) a_mode = 1'b0;
      beat_a(px3(i, 255 - i, 7));
    end
    drain_a();
    chk("busy_end_f2", a_busy, 0);

    // Rounding windows {1,1,1,2} and {1,1,2,2}
    for (int k = 0; k < 4; k++) push_a(rexp[k], rexp[k], rexp[k], k == 3);
    for (int i = 0; i < 16; i++) beat_a(px3(rpat[i], rpat[i], rpat[i]));
    drain_a();

    // Reset after 9 beats of an average frame
    push_a(av0[0], av1[0], 7, 1'b0);
    push_a(av0[1], av1[1], 7, 1'b0);
    for (int i = 0; i < 9; i++) beat_a(px3(i, 255 - i, 7));
    chk("f4_busy_before_reset", a_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("f4_out_valid_reset", a_ovld, 0);
    chk("f4_busy_reset", a_busy, 0);
    chk("f4_outputs_before_reset", qa.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fresh frame after abort
    for (int k = 0; k < 4; k++) push_a(av0[k], av1[k], 7, k == 3);
    for (int i = 0; i < 16; i++) beat_a(px3(i, 255 - i, 7));
    drain_a();
    chk("busy_end_f5", a_busy, 0);

    // Full-scale N=4 average
    for (int k = 0; k < 4; k++) begin
      e.px = 24'd255;
      e.last = (k == 3);
      qb.push_back(e);
    end
    for (int i = 0; i < 64; i++) beat_b(8'd255);
    drain_b();
    chk("b_busy_end", b_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
